// File: rtl/seq_shift_unit_if.sv
// Request/response bundle between the ALU control FSM and seq_shift_unit.
// SHIFT_FLAGS_EN adds the carry/zero flag signals.
interface seq_shift_unit_if #(
    parameter int WIDTH = 32
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef SHIFT_FLAGS_EN
    logic             carry;
    logic             zero;

    modport master (output start, op, a, amount, input busy, done, result, carry, zero);
    modport slave  (input start, op, a, amount, output busy, done, result, carry, zero);
`else
    modport master (output start, op, a, amount, input busy, done, result);
    modport slave  (input start, op, a, amount, output busy, done, result);
`endif
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit (SHL, SHR, SHRA, ROL, ROR, PASS), STEP bits per cycle.
// Define SHIFT_FLAGS_EN to add carry (last bit out) and zero flags.
module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input logic             clock,
    input logic             clear,
    seq_shift_unit_if.slave bus
);
    localparam int AMT_W = $clog2(WIDTH);
    localparam int CW    = AMT_W + 1;
    localparam logic [CW-1:0] STEP_C  = CW'(STEP);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHRA = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    s;
    logic [CW-1:0]    rs;
`ifdef SHIFT_FLAGS_EN
    logic             carry_w_q, carry_w_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    sm1;
    logic             cout_l, cout_r;
`endif

    // Final step may be shorter than STEP; count never exceeds WIDTH-1.
    assign s  = (count_q > STEP_C) ? STEP_C : count_q;
    assign rs = WIDTH_C - s;
`ifdef SHIFT_FLAGS_EN
    assign sm1    = s - CW'(1);
    assign cout_l = |(work_q & (ONE << rs));
    assign cout_r = |(work_q & (ONE << sm1));
`endif

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        count_d  = count_q;
        op_d     = op_q;
        result_d = result_q;
`ifdef SHIFT_FLAGS_EN
        carry_w_d = carry_w_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.a;
                    op_d    = bus.op;
                    count_d = {1'b0, bus.amount};
`ifdef SHIFT_FLAGS_EN
                    carry_w_d = 1'b0;
`endif
                    if (bus.amount == '0 || bus.op > OP_ROR) state_d = DONE;
                    else                                     state_d = SHIFT;
                end
            end
            SHIFT: begin
                case (op_q)
                    OP_SHL:  work_d = work_q << s;
                    OP_SHR:  work_d = work_q >> s;
                    OP_SHRA: work_d = WIDTH'($signed(work_q) >>> s);
                    OP_ROL:  work_d = (work_q << s) | (work_q >> rs);
                    OP_ROR:  work_d = (work_q >> s) | (work_q << rs);
                    default: work_d = work_q;
                endcase
`ifdef SHIFT_FLAGS_EN
                carry_w_d = (op_q == OP_SHL || op_q == OP_ROL) ? cout_l : cout_r;
`endif
                count_d = count_q - s;
                if (count_d == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Result and flags are only published on entry to DONE.
        if (state_d == DONE && state_q != DONE) begin
            result_d = work_d;
`ifdef SHIFT_FLAGS_EN
            carry_d = carry_w_d;
            zero_d  = (work_d == '0);
`endif
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            work_q   <= '0;
            result_q <= '0;
            count_q  <= '0;
            op_q     <= '0;
`ifdef SHIFT_FLAGS_EN
            carry_w_q <= 1'b0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            count_q  <= count_d;
            op_q     <= op_d;
`ifdef SHIFT_FLAGS_EN
            carry_w_q <= carry_w_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
`endif
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
`ifdef SHIFT_FLAGS_EN
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
`endif
endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: STEP=1 and STEP=4 instances driven with identical stimulus.
module tb_seq_shift_unit;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    seq_shift_unit_if #(.WIDTH(32)) i1 ();
    seq_shift_unit_if #(.WIDTH(32)) i4 ();

    seq_shift_unit #(.WIDTH(32), .STEP(1)) u_s1 (.clock(clock), .clear(clear), .bus(i1));
    seq_shift_unit #(.WIDTH(32), .STEP(4)) u_s4 (.clock(clock), .clear(clear), .bus(i4));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [4:0]  amt;
        logic [31:0] res;
        int          lat1;
        int          lat4;
        logic        cy;
        logic        zr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [4:0] amt);
        i1.start = st; i1.op = op; i1.a = a; i1.amount = amt;
        i4.start = st; i4.op = op; i4.a = a; i4.amount = amt;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int got1, got4;
        logic [31:0] r1, r4;
        logic c1, c4, z1, z4;
        v = vecs[idx];
        got1 = 0; got4 = 0;
        r1 = '0; r4 = '0; c1 = 0; c4 = 0; z1 = 0; z4 = 0;
        drive(1'b1, v.op, v.a, v.amt);
        for (int k = 1; k <= 60 && (got1 == 0 || got4 == 0); k++) begin
            @(posedge clock); #1;
            if (k == 1) begin i1.start = 1'b0; i4.start = 1'b0; end
            if (got1 == 0 && i1.done) begin
                got1 = k; r1 = i1.result;
`ifdef SHIFT_FLAGS_EN
                c1 = i1.carry; z1 = i1.zero;
`endif
            end
            if (got4 == 0 && i4.done) begin
                got4 = k; r4 = i4.result;
`ifdef SHIFT_FLAGS_EN
                c4 = i4.carry; z4 = i4.zero;
`endif
            end
        end
        chk($sformatf("v%0d lat_step1", idx), 32'(got1), 32'(v.lat1));
        chk($sformatf("v%0d res_step1", idx), r1, v.res);
        chk($sformatf("v%0d lat_step4", idx), 32'(got4), 32'(v.lat4));
        chk($sformatf("v%0d res_step4", idx), r4, v.res);
`ifdef SHIFT_FLAGS_EN
        chk($sformatf("v%0d carry_step1", idx), 32'(c1), 32'(v.cy));
        chk($sformatf("v%0d zero_step1", idx),  32'(z1), 32'(v.zr));
        chk($sformatf("v%0d carry_step4", idx), 32'(c4), 32'(v.cy));
        chk($sformatf("v%0d zero_step4", idx),  32'(z4), 32'(v.zr));
`endif
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int ndone;
        vecs[0]  = '{3'd0, 32'h0000_0012, 5'd1,  32'h0000_0024, 2,  2, 1'b0, 1'b0};
        vecs[1]  = '{3'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 5,  2, 1'b0, 1'b0};
        vecs[2]  = '{3'd4, 32'h0000_0001, 5'd1,  32'h8000_0000, 2,  2, 1'b1, 1'b0};
        vecs[3]  = '{3'd3, 32'h8000_0001, 5'd4,  32'h0000_0018, 5,  2, 1'b0, 1'b0};
        vecs[4]  = '{3'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  1, 1'b0, 1'b0};
        vecs[5]  = '{3'd7, 32'h1234_5678, 5'd5,  32'h1234_5678, 1,  1, 1'b0, 1'b0};
        vecs[6]  = '{3'd1, 32'h0000_0003, 5'd2,  32'h0000_0000, 3,  2, 1'b1, 1'b1};
        vecs[7]  = '{3'd0, 32'h0000_0001, 5'd0,  32'h0000_0001, 1,  1, 1'b0, 1'b0};
        vecs[8]  = '{3'd0, 32'h0000_0003, 5'd31, 32'h8000_0000, 32, 9, 1'b1, 1'b0};
        vecs[9]  = '{3'd2, 32'h7FFF_FFFF, 5'd5,  32'h03FF_FFFF, 6,  3, 1'b1, 1'b0};
        vecs[10] = '{3'd4, 32'h1234_5678, 5'd8,  32'h7812_3456, 9,  3, 1'b0, 1'b0};
        vecs[11] = '{3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32, 9, 1'b0, 1'b0};

        drive(1'b0, 3'd0, 32'h0, 5'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset busy",   32'(i1.busy), 32'd0);
        chk("reset done",   32'(i1.done), 32'd0);
        chk("reset result", i1.result, 32'h0);
        chk("reset result4", i4.result, 32'h0);
`ifdef SHIFT_FLAGS_EN
        chk("reset carry", 32'(i1.carry), 32'd0);
        chk("reset zero",  32'(i1.zero),  32'd0);
`endif
        @(negedge clock) clear = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 12; i++) run_vec(i);

        // SHL 1 by 8; start during SHIFT is dropped, result holds old value until DONE
        drive(1'b1, 3'd0, 32'h1, 5'd8);
        @(posedge clock); #1;
        drive(1'b0, 3'd0, 32'h1, 5'd8);
        chk("seqA busy e1", 32'(i1.busy), 32'd1);
        @(posedge clock); #1;
        drive(1'b1, 3'd1, 32'hFFFF, 5'd3);
        @(posedge clock); #1;
        drive(1'b0, 3'd0, 32'h0, 5'd0);
        chk("seqA busy e3", 32'(i1.busy), 32'd1);
        chk("seqA hold e3", i1.result, 32'hFFFF_FFFF);
        ndone = 0;
        for (int k = 4; k <= 8; k++) begin
            @(posedge clock); #1;
            if (i1.done) ndone++;
        end
        chk("seqA early done", 32'(ndone), 32'd0);
        @(posedge clock); #1;
        chk("seqA done e9", 32'(i1.done), 32'd1);
        chk("seqA res e9", i1.result, 32'h0000_0100);
        // start held across the DONE cycle: ignored there, accepted one edge later
        drive(1'b1, 3'd7, 32'hA5A5_A5A5, 5'd0);
        @(posedge clock); #1;
        chk("seqA done e10", 32'(i1.done), 32'd0);
        chk("seqA busy e10", 32'(i1.busy), 32'd0);
        @(posedge clock); #1;
        drive(1'b0, 3'd0, 32'h0, 5'd0);
        chk("seqA done e11", 32'(i1.done), 32'd1);
        chk("seqA res e11", i1.result, 32'hA5A5_A5A5);
        repeat (3) @(posedge clock);
        #1;

        // clear mid-operation abandons it
        drive(1'b1, 3'd0, 32'h1, 5'd8);
        @(posedge clock); #1;
        drive(1'b0, 3'd0, 32'h0, 5'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) clear = 1'b1;
        #1;
        chk("seqB busy clr",   32'(i1.busy), 32'd0);
        chk("seqB result clr", i1.result, 32'h0);
        chk("seqB done clr",   32'(i1.done), 32'd0);
        @(negedge clock) clear = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            if (i1.done || i1.busy) ndone++;
        end
        chk("seqB no done", 32'(ndone), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
